// File: rtl/bf16_pkg.sv
// Shared bfloat16 types, constants and feeder FSM state encoding.
// Also provides the denormal flush helper used by the operand feeder.
package bf16_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

    localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
    localparam logic [7:0]  BF16_EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        StWaitReady = 2'd0,
        StPhaseA    = 2'd1,
        StPhaseB    = 2'd2
    } feeder_state_e;

    // Subnormal inputs collapse to a zero that keeps the operand's sign.
    function automatic logic [15:0] bf16_flush_denorm(input logic [15:0] x);
        bf16_t v;
        v = bf16_t'(x);
        if (v.exp == 8'h00 && v.man != 7'h00) begin
            return {v.sign, 15'b0};
        end
        return x;
    endfunction

endpackage

// File: rtl/bf16_pair_fifo.sv
// Operand-pair FIFO: 32-bit entries {a, b}, power-of-two DEPTH, registered occupancy.
// Push is refused when full and pop when empty; pointers wrap naturally.
module bf16_pair_fifo
    import bf16_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     i_push,
    input  logic [31:0]              i_wdata,
    input  logic                     i_pop,
    output logic [31:0]              o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/bf16_operand_feeder.sv
// Feeds queued bfloat16 operand pairs to a two-phase adder, one launch per adder_ready pulse.
// Build option BF16_FEEDER_FLUSH_DENORM_EN: flush subnormal operands to signed zero at pop.
module bf16_operand_feeder
    import bf16_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    input  logic                     adder_ready,
    output logic [15:0]              op_a,
    output logic [15:0]              op_b,
    output logic                     issued,
    output logic                     bubble,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               bubble_cnt,
    output logic                     protocol_err
);

    feeder_state_e r_state;
    feeder_state_e w_state_next;

    logic [31:0] w_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_launch;
    logic        w_pop;
    logic        w_bubble_take;
    logic        w_proto_hit;
    logic [15:0] w_next_a;
    logic [15:0] w_next_b;

    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic        r_issued;
    logic        r_bubble;
    logic [7:0]  r_bubble_cnt;
    logic        r_protocol_err;

    assign in_ready = ~w_fifo_full;
    assign w_push   = in_valid & in_ready;

    bf16_pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .nreset  (nreset),
        .i_push  (w_push),
        .i_wdata ({in_a, in_b}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef BF16_FEEDER_FLUSH_DENORM_EN
    assign w_next_a = bf16_flush_denorm(w_head[31:16]);
    assign w_next_b = bf16_flush_denorm(w_head[15:0]);
`else
    assign w_next_a = w_head[31:16];
    assign w_next_b = w_head[15:0];
`endif

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_proto_hit  = 1'b0;
        unique case (r_state)
            StWaitReady: begin
                if (adder_ready) begin
                    w_launch     = 1'b1;
                    w_state_next = StPhaseA;
                end
            end
            StPhaseA: begin
                w_proto_hit  = adder_ready;
                w_state_next = StPhaseB;
            end
            StPhaseB: begin
                w_proto_hit  = adder_ready;
                w_state_next = StWaitReady;
            end
            default: begin
                w_state_next = StWaitReady;
            end
        endcase
    end

    // Emptiness is the registered view, so a same-cycle push into an empty FIFO still bubbles.
    assign w_pop         = w_launch & ~w_fifo_empty;
    assign w_bubble_take = w_launch & w_fifo_empty;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state        <= StWaitReady;
            r_op_a         <= BF16_POS_ZERO;
            r_op_b         <= BF16_POS_ZERO;
            r_issued       <= 1'b0;
            r_bubble       <= 1'b0;
            r_bubble_cnt   <= 8'h00;
            r_protocol_err <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_issued <= w_pop;
            r_bubble <= w_bubble_take;
            // Operands hold from PHASE_A until the next launch.
            if (w_launch) begin
                r_op_a <= w_pop ? w_next_a : BF16_POS_ZERO;
                r_op_b <= w_pop ? w_next_b : BF16_POS_ZERO;
            end
            if (w_bubble_take && r_bubble_cnt != 8'hFF) begin
                r_bubble_cnt <= r_bubble_cnt + 8'h01;
            end
            if (w_proto_hit) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign issued       = r_issued;
    assign bubble       = r_bubble;
    assign bubble_cnt   = r_bubble_cnt;
    assign protocol_err = r_protocol_err;

endmodule
